// File: rtl/alu_share_arb_if.sv
// Bundle of requester, response and ALU-side signals for alu_share_arb.
// The master side is the environment (requesters plus ALU); the slave side is the arbiter.
interface alu_share_arb_if #(
    parameter int unsigned N_REQ = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [32*N_REQ-1:0] req_a;
    logic [32*N_REQ-1:0] req_b;
    logic [4*N_REQ-1:0] req_op;
    logic [5*N_REQ-1:0] req_shamt;
    logic [N_REQ-1:0]   resp_valid;
    logic [N_REQ-1:0]   resp_ready;
    logic [31:0]        resp_c;
    logic               resp_zero;
    logic [31:0]        alu_a;
    logic [31:0]        alu_b;
    logic [3:0]         alu_op;
    logic [4:0]         alu_shamt;
    logic [31:0]        alu_c;
    logic               alu_zero;
    logic               busy;

    modport master (
        output req_valid, req_a, req_b, req_op, req_shamt, resp_ready, alu_c, alu_zero,
        input  req_ready, resp_valid, resp_c, resp_zero, alu_a, alu_b, alu_op, alu_shamt, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_shamt, resp_ready, alu_c, alu_zero,
        output req_ready, resp_valid, resp_c, resp_zero, alu_a, alu_b, alu_op, alu_shamt, busy
    );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one ALU among N_REQ requesters: grant, register operands,
// capture result, then hold a valid/ready response to the granted requester.
module alu_share_arb #(
    parameter int unsigned N_REQ = 2
) (
    input logic          clk,
    input logic          rst,
    alu_share_arb_if.slave bus
);
    localparam int unsigned          IdxW    = $clog2(N_REQ);
    localparam logic [3:0]           AluNop  = 4'b0000;
    localparam logic [IdxW-1:0]      LastRst = IdxW'(N_REQ - 1);
    localparam logic [N_REQ-1:0]     OneLsb  = N_REQ'(1);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e             state_q;
    logic [IdxW-1:0]    last_q;
    logic [IdxW-1:0]    gnt_q;
    logic [31:0]        alu_a_q;
    logic [31:0]        alu_b_q;
    logic [3:0]         alu_op_q;
    logic [4:0]         alu_shamt_q;
    logic [31:0]        resp_c_q;
    logic               resp_zero_q;
    logic [N_REQ-1:0]   resp_valid_q;
    logic               busy_q;

    logic [31:0]        a_arr     [N_REQ];
    logic [31:0]        b_arr     [N_REQ];
    logic [3:0]         op_arr    [N_REQ];
    logic [4:0]         shamt_arr [N_REQ];

    logic               grant_found;
    logic [IdxW-1:0]    grant_sel;
    logic [IdxW-1:0]    cand;
    logic [N_REQ-1:0]   req_ready_d;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign a_arr[i]     = bus.req_a[32*i+31:32*i];
        assign b_arr[i]     = bus.req_b[32*i+31:32*i];
        assign op_arr[i]    = bus.req_op[4*i+3:4*i];
        assign shamt_arr[i] = bus.req_shamt[5*i+4:5*i];
    end

    // Scan from last+1 upward so the most recently served requester has lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_sel   = '0;
        cand        = '0;
        req_ready_d = '0;
        if (state_q == StIdle && !rst) begin
            for (int unsigned k = 1; k <= N_REQ; k++) begin
                cand = IdxW'((32'(last_q) + k) % N_REQ);
                if (!grant_found && bus.req_valid[cand]) begin
                    grant_found = 1'b1;
                    grant_sel   = cand;
                end
            end
            if (grant_found) begin
                req_ready_d[grant_sel] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_q       <= LastRst;
            gnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= AluNop;
            alu_shamt_q  <= '0;
            resp_c_q     <= '0;
            resp_zero_q  <= 1'b0;
            resp_valid_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant_found) begin
                        alu_a_q     <= a_arr[grant_sel];
                        alu_b_q     <= b_arr[grant_sel];
                        alu_op_q    <= op_arr[grant_sel];
                        alu_shamt_q <= shamt_arr[grant_sel];
                        gnt_q       <= grant_sel;
                        busy_q      <= 1'b1;
                        state_q     <= StExec;
                    end
                end
                StExec: begin
                    resp_c_q     <= bus.alu_c;
                    resp_zero_q  <= bus.alu_zero;
                    resp_valid_q <= OneLsb << gnt_q;
                    state_q      <= StResp;
                end
                StResp: begin
                    if (bus.resp_ready[gnt_q]) begin
                        last_q       <= gnt_q;
                        alu_op_q     <= AluNop;
                        resp_valid_q <= '0;
                        busy_q       <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_d;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_c     = resp_c_q;
    assign bus.resp_zero  = resp_zero_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.alu_shamt  = alu_shamt_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed ops, round-robin, back-pressure,
// reset mid-op and randomized traffic against a transaction-level reference.
module tb_alu_share_arb;
    localparam int unsigned N = 2;

    localparam logic [3:0] OpNop  = 4'd0;
    localparam logic [3:0] OpAdd  = 4'd1;
    localparam logic [3:0] OpSub  = 4'd2;
    localparam logic [3:0] OpAnd  = 4'd3;
    localparam logic [3:0] OpOr   = 4'd4;
    localparam logic [3:0] OpSlt  = 4'd5;
    localparam logic [3:0] OpSltu = 4'd6;
    localparam logic [3:0] OpSll  = 4'd7;
    localparam logic [3:0] OpSrl  = 4'd8;
    localparam logic [3:0] OpSra  = 4'd9;
    localparam logic [3:0] OpXor  = 4'd10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_share_arb_if #(.N_REQ(N)) bus ();

    alu_share_arb #(.N_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0]  a_v  [N];
    logic [31:0]  b_v  [N];
    logic [3:0]   op_v [N];
    logic [4:0]   sh_v [N];
    logic [N-1:0] vmask;
    int           last_g;

    function automatic logic [31:0] alu_fn(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                           logic [4:0] sh);
        case (op)
            OpAdd:   return a + b;
            OpSub:   return a - b;
            OpAnd:   return a & b;
            OpOr:    return a | b;
            OpXor:   return a ^ b;
            OpSlt:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OpSltu:  return (a < b) ? 32'd1 : 32'd0;
            OpSll:   return b << sh;
            OpSrl:   return b >> sh;
            OpSra:   return $unsigned($signed(b) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    // Behavioural ALU standing in for the shared unit.
    assign bus.alu_c    = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_shamt);
    assign bus.alu_zero = (bus.alu_c == 32'd0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_a[32*i +: 32]    = a_v[i];
            bus.req_b[32*i +: 32]    = b_v[i];
            bus.req_op[4*i +: 4]     = op_v[i];
            bus.req_shamt[5*i +: 5]  = sh_v[i];
        end
        bus.req_valid = vmask;
    endtask

    function automatic int pick(logic [N-1:0] m, int last);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (m[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [31:0] oh(int g);
        logic [31:0] r;
        r = 32'd0;
        r[g] = 1'b1;
        return r;
    endfunction

    task automatic set_op(input int r, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh);
        a_v[r] = a; b_v[r] = b; op_v[r] = op; sh_v[r] = sh;
    endtask

    task automatic set_rand(input int r);
        a_v[r]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        b_v[r]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        op_v[r] = 4'($urandom_range(1, 10));
        sh_v[r] = 5'($urandom_range(0, 31));
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_c", bus.resp_c, 32'd0);
        check("rst_resp_zero", 32'(bus.resp_zero), 32'd0);
        check("rst_alu_a", bus.alu_a, 32'd0);
        check("rst_alu_b", bus.alu_b, 32'd0);
        check("rst_alu_op", 32'(bus.alu_op), 32'(OpNop));
        check("rst_alu_shamt", 32'(bus.alu_shamt), 32'd0);
    endtask

    // One full transaction from the accept cycle; leaves the bench just after entry to IDLE.
    task automatic serve(input int stall, input bit renew, output int g, output logic [31:0] c);
        logic [31:0] ec;
        drive();
        #1;
        g = pick(vmask, last_g);
        check("req_ready_grant", 32'(bus.req_ready), oh(g));
        check("resp_valid_at_accept", 32'(bus.resp_valid), 32'd0);
        ec = alu_fn(op_v[g], a_v[g], b_v[g], sh_v[g]);
        tick();
        check("exec_busy", 32'(bus.busy), 32'd1);
        check("exec_alu_a", bus.alu_a, a_v[g]);
        check("exec_alu_b", bus.alu_b, b_v[g]);
        check("exec_alu_op", 32'(bus.alu_op), 32'(op_v[g]));
        check("exec_alu_shamt", 32'(bus.alu_shamt), 32'(sh_v[g]));
        check("exec_req_ready", 32'(bus.req_ready), 32'd0);
        check("exec_resp_valid", 32'(bus.resp_valid), 32'd0);
        if (renew) set_rand(g);
        else vmask[g] = 1'b0;
        drive();
        tick();
        check("resp_valid", 32'(bus.resp_valid), oh(g));
        check("resp_c", bus.resp_c, ec);
        check("resp_zero", 32'(bus.resp_zero), (ec == 32'd0) ? 32'd1 : 32'd0);
        c = bus.resp_c;
        for (int s = 0; s < stall; s++) begin
            bus.resp_ready = ~oh(g);
            tick();
            check("hold_resp_valid", 32'(bus.resp_valid), oh(g));
            check("hold_resp_c", bus.resp_c, ec);
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
            check("hold_busy", 32'(bus.busy), 32'd1);
        end
        bus.resp_ready = N'(oh(g));
        tick();
        bus.resp_ready = '0;
        check("idle_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_alu_op_nop", 32'(bus.alu_op), 32'(OpNop));
        last_g = g;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          g;
        int          prev;
        logic [31:0] c;

        for (int i = 0; i < N; i++) set_op(i, OpNop, 32'd0, 32'd0, 5'd0);
        vmask          = '0;
        bus.resp_ready = '0;
        drive();
        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs();
        rst    = 1'b0;
        last_g = N - 1;

        // Directed ops
        set_op(0, OpAdd, 32'd5, 32'd7, 5'd0);
        vmask = 2'b01;
        serve(0, 1'b0, g, c);
        check("add_grant", 32'(g), 32'd0);
        check("add_result", c, 32'd12);

        set_op(1, OpSub, 32'd9, 32'd9, 5'd0);
        vmask = 2'b10;
        serve(0, 1'b0, g, c);
        check("sub_result", c, 32'd0);
        check("sub_zero_flag", 32'(bus.resp_zero), 32'd1);

        set_op(0, OpSlt, 32'hFFFF_FFFF, 32'd1, 5'd0);
        vmask = 2'b01;
        serve(1, 1'b0, g, c);
        check("slt_result", c, 32'd1);

        set_op(1, OpSltu, 32'hFFFF_FFFF, 32'd1, 5'd0);
        vmask = 2'b10;
        serve(0, 1'b0, g, c);
        check("sltu_result", c, 32'd0);

        set_op(0, OpSll, 32'd0, 32'd1, 5'd31);
        vmask = 2'b01;
        serve(0, 1'b0, g, c);
        check("sll_result", c, 32'h8000_0000);

        // Round-robin under continuous requests
        set_rand(0);
        set_rand(1);
        vmask = 2'b11;
        prev  = last_g;
        for (int i = 0; i < 6; i++) begin
            serve(0, 1'b1, g, c);
            check("rr_alternate", 32'(g), 32'(prev ^ 1));
            prev = g;
        end

        // Back-pressure then hand-over to the other requester
        serve(5, 1'b1, g, c);
        prev = g;
        serve(0, 1'b1, g, c);
        check("bp_other_granted", 32'(g), 32'(prev ^ 1));

        // Reset while in EXEC with last pointing at requester 0
        vmask = 2'b01;
        serve(0, 1'b1, g, c);
        vmask = 2'b11;
        drive();
        #1;
        check("pre_reset_grant", 32'(bus.req_ready), 32'd2);
        tick();
        rst = 1'b1;
        tick();
        check_reset_outputs();
        rst    = 1'b0;
        last_g = N - 1;
        serve(0, 1'b1, g, c);
        check("post_reset_first_grant", 32'(g), 32'd0);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                vmask = '0;
                drive();
                #1;
                check("idle_no_ready", 32'(bus.req_ready), 32'd0);
                check("idle_not_busy", 32'(bus.busy), 32'd0);
                tick();
            end else begin
                vmask = N'($urandom_range(1, (1 << N) - 1));
                for (int r = 0; r < N; r++) set_rand(r);
                serve(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), g, c);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Round-robin arbiter and sequencer that shares one `alu` instance among `N_REQ` requesters: address-generation, branch-compare and multi-cycle control units in the core. It accepts one operation per grant and registers the operands into the ALU. It then captures the ALU result and Zero flag and returns them to the granted requester over a valid/ready response handshake. Ops use the `ALU_*` codes from `ctrl_encode_def.v`, passed through unchanged.

## Interface
- `N_REQ`, 2, number of requesters; legal range 2..8.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester operation valid.
- `req_ready`  out  N_REQ  one-hot accept; handshake completes when `req_valid[i] & req_ready[i]`.
- `req_a`  in  32*N_REQ  operand A; slice i is `[32*i+31:32*i]`.
- `req_b`  in  32*N_REQ  operand B.
- `req_op`  in  4*N_REQ  ALUOp code.
- `req_shamt`  in  5*N_REQ  shift amount.
- `resp_valid`  out  N_REQ  one-hot result valid.
- `resp_ready`  in  N_REQ  per-requester result accept.
- `resp_c`  out  32  registered ALU result, shared by all requesters.
- `resp_zero`  out  1  registered ALU Zero flag.
- `alu_a`, `alu_b`  out  32 each  registered operands to the ALU.
- `alu_op`  out  4  registered ALUOp.
- `alu_shamt`  out  5  registered shift amount.
- `alu_c`  in  32  ALU result (combinational from the `alu_*` outputs).
- `alu_zero`  in  1  ALU Zero.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Three-state encoding.
- **IDLE**
  - If any `req_valid` is high, grant the first valid requester found scanning from `last+1` upward, modulo N_REQ.
  - Drive `req_ready` one-hot to that requester for this cycle only. `req_ready` is combinational from `req_valid` and `last`.
  - On the clock edge: latch that requester's A/B/op/shamt into the `alu_*` registers, record the grant index in `gnt`, and go to EXEC.
  - If no request is valid, stay in IDLE with `req_ready` = 0.
- **EXEC**
  - The ALU evaluates the registered operands.
  - On the clock edge: `resp_c <= alu_c`, `resp_zero <= alu_zero`, and go to RESP.
- **RESP**
  - `resp_valid[gnt]` = 1; all other bits are 0.
  - When `resp_ready[gnt]` is high: on the clock edge, set `last <= gnt`, `alu_op <= ALU_NOP`, and go to IDLE.
  - Otherwise hold in RESP; `resp_c` and `resp_zero` stay stable.
- `req_ready` = 0 in EXEC and RESP. Requests from any requester, including the granted one, wait.
- A requester that drops `req_valid` before being granted loses nothing; no request state is stored before the grant.
- `resp_ready` on non-granted bits is ignored.
- Reset (at any time, including mid-EXEC or mid-RESP):
  - state = IDLE, `last` = N_REQ-1 (requester 0 wins first), `gnt` = 0.
  - `alu_a`/`alu_b`/`alu_shamt` = 0, `alu_op` = ALU_NOP.
  - `resp_c` = 0, `resp_zero` = 0.
  - `req_ready`, `resp_valid`, `busy` = 0.
  - An in-flight operation is dropped with no response.
- Arithmetic is performed entirely by the ALU; this block adds no width changes.

## Timing
- Accept handshake in cycle T.
- `alu_*` outputs are valid from T+1.
- `resp_valid` is high from T+2.
- With `resp_ready` tied high: one op per 3 cycles, and the next grant is possible in T+3.
- Fairness: under continuous requests from all N_REQ requesters, each is granted exactly once every N_REQ grants.
- `resp_valid` never rises in the same cycle as `req_ready`.

## Test plan
- **Single request:** req0 ADD A=5, B=7 → `req_ready[0]` in cycle T; `resp_valid[0]` at T+2; `resp_c`=12, `resp_zero`=0.
- **Zero flag and signed compares:**
  - SUB 9-9 → `resp_c`=0, `resp_zero`=1.
  - SLT A=0xFFFFFFFF, B=1 → `resp_c`=1.
  - SLTU with the same operands → `resp_c`=0.
  - SLL B=1, shamt=31 → `resp_c`=0x80000000.
- **Round-robin:** req0 and req1 held valid continuously with N_REQ=2 → grants alternate 0,1,0,1; each `resp_c` matches its own operands.
- **Back-pressure:** hold `resp_ready[gnt]`=0 for 5 cycles → `resp_valid` stays high, `resp_c` stable, `req_ready` stays 0; release → IDLE next cycle and the other requester is granted.
- **Reset mid-op:** assert `rst` in EXEC → next cycle state is IDLE, all outputs at reset values, no `resp_valid`; the first grant after reset goes to req0.
